// File: rtl/game_step_sequencer.sv
// Game step sequencer: paces snake steps from a free-running tick and walks the
// link / move / collide handshakes, flagging a stuck handshake as step_err.
package game_mode_pkg;
    typedef enum logic [1:0] {
        MODE_MENU = 2'd0,
        MODE_GAME = 2'd1,
        MODE_LOSE = 2'd2,
        MODE_WIN  = 2'd3
    } game_mode;
endpackage

module game_step_sequencer
    import game_mode_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 7_500_000,
    parameter int unsigned ACK_TIMEOUT = 750_000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic        clk_75,
    input  logic        rst_n,
    input  game_mode    mode,
    input  logic        singleplayer,
    input  logic        link_ack,
    input  logic        move_ack,
    input  logic        coll_ack,
    output logic        link_req,
    output logic        move_req,
    output logic        coll_req,
    output logic        step_done,
    output logic        overrun,
    output logic        step_err,
    output logic [15:0] step_count
);

    localparam logic [CNT_W-1:0] StepLast = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] AckLast  = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StSync,
        StMove,
        StCollide,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic [15:0]       step_count_q, step_count_d;
    logic              step_done_q, step_done_d;
    logic              overrun_q, overrun_d;
    logic              in_game;
    logic              tick;
    logic              phase_ack;

    assign in_game = (mode == MODE_GAME);
    assign tick    = (tick_cnt_q == StepLast);

    // Reqs are pure state decodes, so an async reset drops them immediately.
    always_comb begin
        phase_ack = 1'b0;
        unique case (state_q)
            StSync:    phase_ack = link_ack;
            StMove:    phase_ack = move_ack;
            StCollide: phase_ack = coll_ack;
            default:   phase_ack = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        to_cnt_d     = to_cnt_q;
        step_count_d = step_count_q;
        step_done_d  = 1'b0;
        overrun_d    = 1'b0;

        if (!in_game) begin
            state_d    = StIdle;
            tick_cnt_d = '0;
            to_cnt_d   = '0;
        end else begin
            if (state_q inside {StWaitTick, StSync, StMove, StCollide}) begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    state_d      = StWaitTick;
                    step_count_d = '0;
                    tick_cnt_d   = '0;
                    to_cnt_d     = '0;
                end
                StWaitTick: begin
                    if (tick) state_d = singleplayer ? StMove : StSync;
                end
                StSync, StMove, StCollide: begin
                    // A tick inside a phase is dropped; the phase carries on.
                    overrun_d = tick;
                    if (phase_ack) begin
                        to_cnt_d = '0;
                        if (state_q == StSync) begin
                            state_d = StMove;
                        end else if (state_q == StMove) begin
                            state_d = StCollide;
                        end else begin
                            state_d      = StWaitTick;
                            step_done_d  = 1'b1;
                            step_count_d = step_count_q + 16'd1;
                        end
                    end else if (to_cnt_q == AckLast) begin
                        state_d = StErr;
                    end else begin
                        to_cnt_d = to_cnt_q + CNT_W'(1);
                    end
                end
                StErr: begin
                    state_d = StErr;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_75 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            to_cnt_q     <= '0;
            step_count_q <= '0;
            step_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            to_cnt_q     <= to_cnt_d;
            step_count_q <= step_count_d;
            step_done_q  <= step_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign link_req   = (state_q == StSync);
    assign move_req   = (state_q == StMove);
    assign coll_req   = (state_q == StCollide);
    assign step_err   = (state_q == StErr);
    assign step_done  = step_done_q;
    assign overrun    = overrun_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_game_step_sequencer.sv
// Bench for game_step_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based step model.
module tb_game_step_sequencer;
    import game_mode_pkg::*;

    localparam int STEP = 8;
    localparam int TO   = 4;
    localparam int RLINK = 0;
    localparam int RMOVE = 1;
    localparam int RCOLL = 2;

    logic        clk_75 = 1'b0;
    logic        rst_n;
    game_mode    mode;
    logic        singleplayer, link_ack, move_ack, coll_ack;
    logic        link_req, move_req, coll_req, step_done, overrun, step_err;
    logic [15:0] step_count;

    int checks = 0;
    int passes = 0;

    always #5 clk_75 = ~clk_75;

    game_step_sequencer #(
        .STEP_CYCLES (STEP),
        .ACK_TIMEOUT (TO),
        .CNT_W       (8)
    ) dut (
        .clk_75       (clk_75),
        .rst_n        (rst_n),
        .mode         (mode),
        .singleplayer (singleplayer),
        .link_ack     (link_ack),
        .move_ack     (move_ack),
        .coll_ack     (coll_ack),
        .link_req     (link_req),
        .move_req     (move_req),
        .coll_req     (coll_req),
        .step_done    (step_done),
        .overrun      (overrun),
        .step_err     (step_err),
        .step_count   (step_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {link_req, move_req, coll_req, step_done, overrun, step_err, step_count}
    function automatic logic [21:0] outs();
        return {link_req, move_req, coll_req, step_done, overrun, step_err, step_count};
    endfunction

    typedef struct {
        game_mode    m;
        logic        sp, la, ma, ca;
        logic [21:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input game_mode m, input logic sp, input logic la,
                                input logic ma, input logic ca, input logic [5:0] flags,
                                input logic [15:0] cnt);
        vec_t v;
        v.m = m; v.sp = sp; v.la = la; v.ma = ma; v.ca = ca;
        v.exp = {flags, cnt};
        vecs.push_back(v);
    endfunction

    // Event log for the hand-written sequences; cyc counts edges since entry.
    int cyc, hi_l, hi_m, hi_c, max_m;
    int done_at[$], ovr_at[$], lrise[$], mrise[$], crise[$];
    bit overlap;

    task automatic clear_log();
        cyc = 0; hi_l = 0; hi_m = 0; hi_c = 0; max_m = 0; overlap = 0;
        done_at.delete(); ovr_at.delete(); lrise.delete(); mrise.delete(); crise.delete();
    endtask

    task automatic enter_game(input logic sp);
        mode = MODE_MENU; link_ack = 0; move_ack = 0; coll_ack = 0;
        @(posedge clk_75); #1;
        mode = MODE_GAME; singleplayer = sp;
        clear_log();
    endtask

    // Each ack answers in the d-th cycle its req is high (d = 0: never).
    task automatic run(input int n, input int dl, input int dm, input int dc);
        repeat (n) begin
            @(posedge clk_75); #1;
            cyc++;
            hi_l = link_req ? hi_l + 1 : 0;
            hi_m = move_req ? hi_m + 1 : 0;
            hi_c = coll_req ? hi_c + 1 : 0;
            if (hi_l == 1) lrise.push_back(cyc);
            if (hi_m == 1) mrise.push_back(cyc);
            if (hi_c == 1) crise.push_back(cyc);
            if (hi_m > max_m) max_m = hi_m;
            if (step_done) done_at.push_back(cyc);
            if (overrun) ovr_at.push_back(cyc);
            if (int'(link_req) + int'(move_req) + int'(coll_req) > 1) overlap = 1;
            link_ack = link_req && dl != 0 && hi_l == dl;
            move_ack = move_req && dm != 0 && hi_m == dm;
            coll_ack = coll_req && dc != 0 && hi_c == dc;
        end
    endtask

    // Reference model: a step is a list of pending requests served in order.
    bit          m_in_game, m_err, m_done, m_ovr;
    int          m_pend[$];
    int          m_wait, m_cyc;
    logic [15:0] m_count;

    task automatic model_reset();
        m_in_game = 0; m_err = 0; m_done = 0; m_ovr = 0;
        m_pend.delete(); m_wait = 0; m_cyc = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit tick, acked;
        m_done = 0; m_ovr = 0;
        if (mode != MODE_GAME) begin
            m_in_game = 0; m_err = 0; m_pend.delete(); m_wait = 0;
        end else if (!m_in_game) begin
            m_in_game = 1; m_cyc = 0; m_count = 0; m_wait = 0; m_pend.delete();
        end else if (!m_err) begin
            tick = (m_cyc % STEP) == STEP - 1;
            m_cyc++;
            if (m_pend.size() == 0) begin
                if (tick) begin
                    if (!singleplayer) m_pend.push_back(RLINK);
                    m_pend.push_back(RMOVE);
                    m_pend.push_back(RCOLL);
                    m_wait = 0;
                end
            end else begin
                m_ovr = tick;
                acked = (m_pend[0] == RLINK) ? link_ack :
                        (m_pend[0] == RMOVE) ? move_ack : coll_ack;
                if (acked) begin
                    void'(m_pend.pop_front());
                    m_wait = 0;
                    if (m_pend.size() == 0) begin
                        m_done = 1;
                        m_count = m_count + 16'd1;
                    end
                end else if (m_wait == TO - 1) begin
                    m_err = 1;
                    m_pend.delete();
                end else begin
                    m_wait++;
                end
            end
        end
    endtask

    function automatic logic [21:0] model_outs();
        logic l, m, c;
        l = m_pend.size() > 0 && m_pend[0] == RLINK;
        m = m_pend.size() > 0 && m_pend[0] == RMOVE;
        c = m_pend.size() > 0 && m_pend[0] == RCOLL;
        return {l, m, c, m_done, m_ovr, m_err, m_count};
    endfunction

    initial begin
        rst_n = 0; mode = MODE_MENU; singleplayer = 1;
        link_ack = 0; move_ack = 0; coll_ack = 0;

        // Single-player step, spurious move_ack in WAIT_TICK, mode exit and re-entry.
        for (int i = 0; i < 8; i++) add(MODE_GAME, 1, 0, 0, 0, 6'b000000, 16'd0);
        add(MODE_GAME, 1, 0, 0, 0, 6'b010000, 16'd0);
        add(MODE_GAME, 1, 0, 0, 0, 6'b010000, 16'd0);
        add(MODE_GAME, 1, 0, 1, 0, 6'b001000, 16'd0);
        add(MODE_GAME, 1, 0, 0, 0, 6'b001000, 16'd0);
        add(MODE_GAME, 1, 0, 0, 1, 6'b000100, 16'd1);
        add(MODE_GAME, 1, 0, 1, 0, 6'b000000, 16'd1);
        add(MODE_GAME, 1, 0, 1, 0, 6'b000000, 16'd1);
        add(MODE_GAME, 1, 0, 0, 0, 6'b000000, 16'd1);
        add(MODE_MENU, 1, 0, 0, 0, 6'b000000, 16'd1);
        add(MODE_MENU, 1, 0, 0, 0, 6'b000000, 16'd1);
        add(MODE_GAME, 1, 0, 0, 0, 6'b000000, 16'd0);

        repeat (2) @(posedge clk_75);
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1;
        mode = MODE_MENU;
        @(posedge clk_75); #1;
        check("idle_outputs", 32'(outs()), 32'd0);

        foreach (vecs[i]) begin
            mode = vecs[i].m; singleplayer = vecs[i].sp;
            link_ack = vecs[i].la; move_ack = vecs[i].ma; coll_ack = vecs[i].ca;
            @(posedge clk_75); #1;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Two-player: five steps, fixed 8-cycle cadence, strict req order.
        enter_game(0);
        run(48, 2, 2, 2);
        check("2p_done_count", done_at.size(), 5);
        check("2p_step_count", 32'(step_count), 5);
        check("2p_no_overlap", 32'(overlap), 0);
        for (int i = 0; i < 5; i++) begin
            if (i < lrise.size()) check($sformatf("2p_link_rise%0d", i), lrise[i], 9 + 8 * i);
            if (i < mrise.size()) check($sformatf("2p_move_rise%0d", i), mrise[i], 11 + 8 * i);
            if (i < crise.size()) check($sformatf("2p_coll_rise%0d", i), crise[i], 13 + 8 * i);
            if (i < done_at.size()) check($sformatf("2p_done%0d", i), done_at[i], 15 + 8 * i);
        end

        // Timeout on move_ack, then leave via LOSE.
        enter_game(1);
        run(20, 2, 0, 2);
        check("to_link_never", lrise.size(), 0);
        check("to_move_rises", mrise.size(), 1);
        check("to_move_high_len", max_m, TO);
        check("to_no_coll", crise.size(), 0);
        check("to_err_held", 32'(outs()), 32'({6'b000001, 16'd0}));
        mode = MODE_LOSE;
        run(1, 0, 0, 0);
        check("to_lose_clears", 32'(outs()), 32'd0);

        // coll_ack in the last allowed cycle wins over the timeout.
        enter_game(1);
        run(16, 0, 2, TO);
        check("late_ack_done_count", done_at.size(), 1);
        if (done_at.size() > 0) check("late_ack_done_cyc", done_at[0], 15);
        check("late_ack_no_err", 32'(step_err), 0);
        check("late_ack_count", 32'(step_count), 1);

        // Overrun: slow two-player step spans a tick.
        enter_game(0);
        run(30, 4, 4, 4);
        check("ovr_pulses", ovr_at.size(), 1);
        if (ovr_at.size() > 0) check("ovr_cyc", ovr_at[0], 17);
        check("ovr_done_count", done_at.size(), 1);
        if (done_at.size() > 0) check("ovr_done_cyc", done_at[0], 21);
        check("ovr_link_rises", lrise.size(), 2);
        if (lrise.size() > 1) check("ovr_next_req_aligned", lrise[1], 25);
        check("ovr_no_err", 32'(step_err), 0);

        // Mode exit with move_req high.
        enter_game(1);
        run(9, 0, 0, 0);
        check("exit_move_high", 32'(move_req), 1);
        mode = MODE_MENU;
        run(1, 0, 0, 0);
        check("exit_move_low", 32'(move_req), 0);

        // Asynchronous reset with coll_req high.
        enter_game(1);
        run(11, 0, 2, 0);
        check("rst_coll_high", 32'(coll_req), 1);
        #2 rst_n = 0;
        #1 check("rst_async_clear", 32'(outs()), 32'd0);
        @(posedge clk_75); #1;
        rst_n = 1;

        // Randomized run against the reference model.
        mode = MODE_MENU; link_ack = 0; move_ack = 0; coll_ack = 0;
        rst_n = 0;
        @(posedge clk_75); #1;
        rst_n = 1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            mode = ($urandom_range(0, 29) == 0) ? game_mode'($urandom_range(0, 3)) : MODE_GAME;
            if ($urandom_range(0, 9) == 0) singleplayer = 1'($urandom_range(0, 1));
            link_ack = 1'($urandom_range(0, 1));
            move_ack = 1'($urandom_range(0, 1));
            coll_ack = 1'($urandom_range(0, 1));
            @(posedge clk_75);
            model_step();
            #1;
            check($sformatf("rand%0d", i), 32'(outs()), 32'(model_outs()));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
